// File: rtl/intr_sched_pkg.sv
// Shared definitions for the interrupt scheduler.
//   NIrq    : number of interrupt lines (multiple of 32)
//   IdW     : width of an interrupt ID
//   NWords  : number of 32-bit enable words
//   intr_st_e : scheduler FSM states
package intr_sched_pkg;

  localparam int unsigned NIrq   = 128;
  localparam int unsigned IdW    = $clog2(NIrq);
  localparam int unsigned NWords = NIrq / 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } intr_st_e;

  typedef logic [IdW-1:0] intr_id_t;

endpackage

// File: rtl/intr_sched_if.sv
// Scheduler <-> core interrupt handshake.
//   intr_req  : request to core (scheduler drives)
//   intr_id   : ID of requested / in-service line (scheduler drives)
//   busy      : a line is in service (scheduler drives)
//   intr_ack  : core accepts request at trap entry (core drives)
//   intr_done : core finished handler, mret (core drives)
//   gie       : core global interrupt enable (core drives)
// Modports: master = scheduler side, slave = core side.
interface intr_sched_if;
  import intr_sched_pkg::*;

  logic     intr_req;
  intr_id_t intr_id;
  logic     busy;
  logic     intr_ack;
  logic     intr_done;
  logic     gie;

  modport master (
    output intr_req, intr_id, busy,
    input  intr_ack, intr_done, gie
  );

  modport slave (
    input  intr_req, intr_id, busy,
    output intr_ack, intr_done, gie
  );

endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index priority encoder.
//   req_i : request vector (N bits, N a multiple of 32)
//   vld_o : any request set
//   id_o  : index of the lowest set request (0 when none)
// Two levels: a 32-bit encoder per group, then lowest valid group wins.
module intr_prio_enc #(
  parameter int unsigned N   = 128,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  output logic           vld_o,
  output logic [IdW-1:0] id_o
);

  localparam int unsigned NGrp = N / 32;

  logic [NGrp-1:0] grp_vld;
  logic [4:0]      grp_id [NGrp];

  always_comb begin
    for (int g = 0; g < NGrp; g++) begin
      grp_vld[g] = |req_i[32*g +: 32];
      grp_id[g]  = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int b = 31; b >= 0; b--) begin
        if (req_i[32*g + b]) grp_id[g] = 5'(b);
      end
    end
  end

  always_comb begin
    vld_o = |grp_vld;
    id_o  = '0;
    for (int g = NGrp - 1; g >= 0; g--) begin
      if (grp_vld[g]) id_o = IdW'(32 * g) + IdW'(grp_id[g]);
    end
  end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: latches/masks requests, picks the lowest enabled
// index and presents it to the core with a req/ack/done handshake.
//   clk, resetn  : clock, asynchronous active-low reset
//   irq_i        : raw interrupt lines, synchronous to clk
//   cfg_we_i     : enable-word write strobe
//   cfg_idx_i    : enable-word index (lines 32*idx .. 32*idx+31)
//   cfg_wdata_i  : enable-word data, 1 = line enabled
//   core         : handshake interface (master side)
// Build option INTR_EDGE_DETECT_EN: rising-edge latched pending bits cleared
// on ack. Without it, pending follows irq_i directly (level mode).
module intr_sched
  import intr_sched_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [NIrq-1:0] irq_i,
  input  logic            cfg_we_i,
  input  logic [1:0]      cfg_idx_i,
  input  logic [31:0]     cfg_wdata_i,
  intr_sched_if.master    core
);

  intr_st_e        state_q, state_d;
  intr_id_t        id_q, id_d;
  logic [NIrq-1:0] en_q, en_d;
  logic [NIrq-1:0] pending;
  logic            win_vld, cand_vld_q;
  intr_id_t        win_id, cand_id_q;

`ifdef INTR_EDGE_DETECT_EN
  logic [NIrq-1:0] irq_q, pend_q, pend_d, clr_mask;

  // Clear-then-set: a new edge on the line being acked keeps it pending.
  always_comb begin
    clr_mask = '0;
    if (state_q == StReq && core.intr_ack) clr_mask[id_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
`else
  assign pending = irq_i;
`endif

  always_comb begin
    en_d = en_q;
    if (cfg_we_i) en_d[32*cfg_idx_i +: 32] = cfg_wdata_i;
  end

  intr_prio_enc #(
    .N   (NIrq),
    .IdW (IdW)
  ) u_prio_enc (
    .req_i (pending & en_q),
    .vld_o (win_vld),
    .id_o  (win_id)
  );

  // State register, enables and registered arbitration result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      id_q       <= '0;
      en_q       <= '0;
      cand_vld_q <= 1'b0;
      cand_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      en_q       <= en_d;
      cand_vld_q <= win_vld;
      cand_id_q  <= win_id;
    end
  end

  // Next state. The ID is captured on grant and held through service, so
  // enable/pending changes cannot disturb an outstanding request.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (cand_vld_q && core.gie) begin
          state_d = StReq;
          id_d    = cand_id_q;
        end
      end
      StReq: begin
        // Ack takes precedence: the core has already entered the trap.
        if (core.intr_ack)  state_d = StService;
        else if (!core.gie) state_d = StIdle;
      end
      StService: begin
        if (core.intr_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core.intr_req = (state_q == StReq);
    core.busy     = (state_q == StService);
    core.intr_id  = id_q;
  end

endmodule
